// File: rtl/datapath_core_param.sv
// datapath_core_param: parametrised single-Xbus datapath (no memory) with
// general registers (register 0 is PC), MAR/WDR/T/I, an ALU writing R and FLG,
// and an iterative shift-add multiplier that owns the R/H result pair.
module datapath_core_param #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int SELW  = $clog2(NREG + 5),
  parameter int DBGW  = $clog2(NREG + 8)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  RD,
  output logic [WIDTH-1:0]  WD,
  output logic [WIDTH-1:0]  MA,
  input  logic [SELW-1:0]   xsrc,
  input  logic [SELW-1:0]   xdst,
  input  logic [3:0]        aluop,
  input  logic              Rwe,
  input  logic              FLGwe,
  input  logic              mul_start,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [WIDTH-1:0]  I,
  output logic [2:0]        SZCy,
  input  logic [DBGW-1:0]   dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_t;

  // Architectural registers
  logic [WIDTH-1:0] gpr [NREG];
  logic [WIDTH-1:0] mar_q, wdr_q, t_q, i_q, r_q, h_q, flg_q;

  // Bus and ALU signals
  logic [WIDTH-1:0] xbus;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic [WIDTH:0]   alu_ext;
  logic [WIDTH-1:0] alu_flg;

  // Multiplier state
  mul_state_t       state_q, state_d;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [WIDTH:0]   upper_sum;
  logic [WIDTH-1:0] prod_flg;
  logic             last_step;
  logic             mul_accept;
  logic             alu_locked;

  assign WD   = wdr_q;
  assign MA   = mar_q;
  assign I    = i_q;
  assign SZCy = flg_q[3:1];

  // Xbus source multiplexer; unassigned codes drive zero
  always_comb begin
    xbus = '0;
    for (int i = 0; i < NREG; i++) begin
      if (xsrc == SELW'(i)) xbus = gpr[i];
    end
    if (xsrc == SELW'(NREG))     xbus = r_q;
    if (xsrc == SELW'(NREG + 1)) xbus = h_q;
    if (xsrc == SELW'(NREG + 2)) xbus = RD;
    if (xsrc == SELW'(NREG + 3)) xbus = flg_q;
    if (xsrc == SELW'(NREG + 4)) xbus = '1;
  end

  // ALU: a = Xbus, b = T, carry-in = FLG[1]; bit WIDTH of the extended result is carry/borrow
  always_comb begin
    alu_res = xbus;
    alu_cy  = 1'b0;
    alu_ext = '0;
    case (aluop)
      4'd1: begin
        alu_ext = {1'b0, xbus} + {1'b0, t_q};
        alu_res = alu_ext[WIDTH-1:0];
        alu_cy  = alu_ext[WIDTH];
      end
      4'd2: begin
        alu_ext = {1'b0, xbus} - {1'b0, t_q};
        alu_res = alu_ext[WIDTH-1:0];
        alu_cy  = alu_ext[WIDTH];
      end
      4'd3: alu_res = xbus & t_q;
      4'd4: alu_res = xbus | t_q;
      4'd5: alu_res = xbus ^ t_q;
      4'd6: begin
        alu_ext = {1'b0, xbus} + {1'b0, t_q} + {{WIDTH{1'b0}}, flg_q[1]};
        alu_res = alu_ext[WIDTH-1:0];
        alu_cy  = alu_ext[WIDTH];
      end
      4'd7: begin
        alu_ext = {1'b0, xbus} - {1'b0, t_q} - {{WIDTH{1'b0}}, flg_q[1]};
        alu_res = alu_ext[WIDTH-1:0];
        alu_cy  = alu_ext[WIDTH];
      end
      4'd8: begin
        alu_res = {xbus[WIDTH-2:0], 1'b0};
        alu_cy  = xbus[WIDTH-1];
      end
      4'd9: begin
        alu_res = {1'b0, xbus[WIDTH-1:1]};
        alu_cy  = xbus[0];
      end
      default: alu_res = xbus;
    endcase
    alu_flg      = '0;
    alu_flg[3:1] = {alu_res[WIDTH-1], (alu_res == '0), alu_cy};
  end

  // One shift-add step: conditionally add the multiplicand to the upper half, then shift right
  always_comb begin
    upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_next  = {upper_sum, acc_q[WIDTH-1:1]};
    prod_flg      = '0;
    prod_flg[3:1] = {acc_next[2*WIDTH-1], (acc_next == '0),
                     (acc_next[2*WIDTH-1:WIDTH] != '0)};
  end

  // Multiplier FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= MUL_IDLE;
    else       state_q <= state_d;
  end

  // Multiplier FSM next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    mul_busy   = 1'b0;
    mul_done   = 1'b0;
    mul_accept = 1'b0;
    last_step  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (mul_start) begin
          mul_accept = 1'b1;
          state_d    = MUL_RUN;
        end
      end
      MUL_RUN: begin
        mul_busy = 1'b1;
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          last_step = 1'b1;
          state_d   = MUL_DONE;
        end
      end
      MUL_DONE: begin
        mul_done = 1'b1;
        state_d  = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
    alu_locked = mul_busy | mul_done;
  end

  // Multiplier operand latch, accumulator and step counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (mul_accept) begin
      cnt_q   <= '0;
      mcand_q <= xbus;
      acc_q   <= {{WIDTH{1'b0}}, t_q};
    end else if (state_q == MUL_RUN) begin
      cnt_q   <= cnt_q + CNTW'(1);
      acc_q   <= acc_next;
    end
  end

  // R/H/FLG: the multiplier writes the product on its final step; otherwise the ALU may write
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q   <= '0;
      h_q   <= '0;
      flg_q <= '0;
    end else if (last_step) begin
      r_q   <= acc_next[WIDTH-1:0];
      h_q   <= acc_next[2*WIDTH-1:WIDTH];
      flg_q <= prod_flg;
    end else if (!alu_locked) begin
      if (Rwe)   r_q   <= alu_res;
      if (FLGwe) flg_q <= alu_flg;
    end
  end

  // Xbus destination registers; at most one destination is written per cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      mar_q <= '0;
      wdr_q <= '0;
      t_q   <= '0;
      i_q   <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (xdst == SELW'(i)) gpr[i] <= xbus;
      end
      if (xdst == SELW'(NREG))     mar_q <= xbus;
      if (xdst == SELW'(NREG + 1)) wdr_q <= xbus;
      if (xdst == SELW'(NREG + 2)) t_q   <= xbus;
      if (xdst == SELW'(NREG + 3)) i_q   <= xbus;
    end
  end

  // Debug read multiplexer
  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (dbg_addr == DBGW'(i)) dbg_data = gpr[i];
    end
    if (dbg_addr == DBGW'(NREG))     dbg_data = mar_q;
    if (dbg_addr == DBGW'(NREG + 1)) dbg_data = wdr_q;
    if (dbg_addr == DBGW'(NREG + 2)) dbg_data = t_q;
    if (dbg_addr == DBGW'(NREG + 3)) dbg_data = i_q;
    if (dbg_addr == DBGW'(NREG + 4)) dbg_data = r_q;
    if (dbg_addr == DBGW'(NREG + 5)) dbg_data = h_q;
    if (dbg_addr == DBGW'(NREG + 6)) dbg_data = flg_q;
    if (dbg_addr == DBGW'(NREG + 7)) dbg_data = xbus;
  end

endmodule

// File: tb/tb_datapath_core_param.sv
// tb_datapath_core_param: scenario tasks for datapath_core_param (WIDTH=8, NREG=4).
// Expected results are pushed to a scoreboard queue when stimulus is driven
// and popped when the DUT produces the result.
module tb_datapath_core_param;

  localparam int WIDTH = 8;
  localparam int NREG  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] RD = '0;
  logic [7:0] WD, MA, I, dbg_data;
  logic [3:0] xsrc = 4'd0;
  logic [3:0] xdst = 4'd8;
  logic [3:0] aluop = 4'd0;
  logic       Rwe = 1'b0, FLGwe = 1'b0, mul_start = 1'b0;
  logic       mul_busy, mul_done;
  logic [2:0] SZCy;
  logic [3:0] dbg_addr = 4'd0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] h;
    logic [2:0] szcy;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  datapath_core_param #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clock(clock), .reset(reset), .RD(RD), .WD(WD), .MA(MA),
    .xsrc(xsrc), .xdst(xdst), .aluop(aluop), .Rwe(Rwe), .FLGwe(FLGwe),
    .mul_start(mul_start), .mul_busy(mul_busy), .mul_done(mul_done),
    .I(I), .SZCy(SZCy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    RD = 8'h5A; xsrc = 4'd6;
    xdst = 4'd7; step();
    xdst = 4'd4; step();
    xdst = 4'd5; step();
    xdst = 4'd0; step();
    xdst = 4'd6; step();
    aluop = 4'd0; Rwe = 1'b1; FLGwe = 1'b1; xdst = 4'd8; step();
    Rwe = 1'b0; FLGwe = 1'b0;
    checks++;
    if (I !== 8'h5A) begin errors++; $display("[TB] FAIL preload_I: got %h expected %h", I, 8'h5A); end
    reset = 1'b1; step(); reset = 1'b0;
    RD = 8'h00; xsrc = 4'd9;
    checks++;
    if (MA !== 8'h00) begin errors++; $display("[TB] FAIL reset_MA: got %h expected 00", MA); end
    checks++;
    if (WD !== 8'h00) begin errors++; $display("[TB] FAIL reset_WD: got %h expected 00", WD); end
    checks++;
    if (I !== 8'h00) begin errors++; $display("[TB] FAIL reset_I: got %h expected 00", I); end
    checks++;
    if (SZCy !== 3'b000) begin errors++; $display("[TB] FAIL reset_SZCy: got %b expected 000", SZCy); end
    checks++;
    if (mul_busy !== 1'b0 || mul_done !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_mul: got busy=%b done=%b expected 0 0", mul_busy, mul_done); end
    for (int a = 0; a < 12; a++) begin
      dbg_addr = 4'(a); #1;
      checks++;
      if (dbg_data !== 8'h00)
        begin errors++; $display("[TB] FAIL reset_dbg%0d: got %h expected 00", a, dbg_data); end
    end
  endtask

  task automatic test_add();
    exp_t e;
    logic [8:0] s9;
    RD = 8'h7F; xsrc = 4'd6; xdst = 4'd6; step();
    RD = 8'h01; xdst = 4'd8; aluop = 4'd1; Rwe = 1'b1; FLGwe = 1'b1;
    s9 = {1'b0, 8'h01} + {1'b0, 8'h7F};
    e.r = s9[7:0]; e.h = 8'h00; e.szcy = {s9[7], (s9[7:0] == 8'h00), s9[8]};
    sb.push_back(e);
    step();
    Rwe = 1'b0; FLGwe = 1'b0; aluop = 4'd0;
    e = sb.pop_front();
    dbg_addr = 4'd8; #1;
    checks++;
    if (dbg_data !== e.r) begin errors++; $display("[TB] FAIL add_R: got %h expected %h", dbg_data, e.r); end
    checks++;
    if (SZCy !== e.szcy) begin errors++; $display("[TB] FAIL add_SZCy: got %b expected %b", SZCy, e.szcy); end
  endtask

  task automatic test_sub_sbc();
    exp_t e;
    logic [8:0] d9;
    logic [7:0] flg_exp;
    RD = 8'h01; xsrc = 4'd6; xdst = 4'd6; step();
    RD = 8'h00; xdst = 4'd8; aluop = 4'd2; Rwe = 1'b1; FLGwe = 1'b1;
    d9 = {1'b0, 8'h00} - {1'b0, 8'h01};
    e.r = d9[7:0]; e.h = 8'h00; e.szcy = {d9[7], (d9[7:0] == 8'h00), d9[8]};
    sb.push_back(e);
    step();
    e = sb.pop_front();
    dbg_addr = 4'd8; #1;
    checks++;
    if (dbg_data !== e.r) begin errors++; $display("[TB] FAIL sub_R: got %h expected %h", dbg_data, e.r); end
    checks++;
    if (SZCy !== e.szcy) begin errors++; $display("[TB] FAIL sub_SZCy: got %b expected %b", SZCy, e.szcy); end
    flg_exp = {4'b0000, e.szcy, 1'b0};
    dbg_addr = 4'd10; #1;
    checks++;
    if (dbg_data !== flg_exp) begin errors++; $display("[TB] FAIL sub_FLG: got %h expected %h", dbg_data, flg_exp); end
    RD = 8'h05; aluop = 4'd7;
    d9 = {1'b0, 8'h05} - {1'b0, 8'h01} - {8'h00, e.szcy[0]};
    e.r = d9[7:0]; e.szcy = {d9[7], (d9[7:0] == 8'h00), d9[8]};
    sb.push_back(e);
    step();
    Rwe = 1'b0; FLGwe = 1'b0; aluop = 4'd0;
    e = sb.pop_front();
    dbg_addr = 4'd8; #1;
    checks++;
    if (dbg_data !== e.r) begin errors++; $display("[TB] FAIL sbc_R: got %h expected %h", dbg_data, e.r); end
    checks++;
    if (SZCy !== e.szcy) begin errors++; $display("[TB] FAIL sbc_SZCy: got %b expected %b", SZCy, e.szcy); end
  endtask

  task automatic test_shift();
    exp_t e;
    RD = 8'h81; xsrc = 4'd6; xdst = 4'd8; Rwe = 1'b1; FLGwe = 1'b1;
    aluop = 4'd8;
    e.r = 8'h02; e.h = 8'h00; e.szcy = 3'b001;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    dbg_addr = 4'd8; #1;
    checks++;
    if (dbg_data !== e.r || SZCy !== e.szcy)
      begin errors++; $display("[TB] FAIL shl: got R=%h SZCy=%b expected R=%h SZCy=%b", dbg_data, SZCy, e.r, e.szcy); end
    aluop = 4'd9;
    e.r = 8'h40; e.szcy = 3'b001;
    sb.push_back(e);
    step();
    Rwe = 1'b0; FLGwe = 1'b0; aluop = 4'd0;
    e = sb.pop_front();
    dbg_addr = 4'd8; #1;
    checks++;
    if (dbg_data !== e.r || SZCy !== e.szcy)
      begin errors++; $display("[TB] FAIL shr: got R=%h SZCy=%b expected R=%h SZCy=%b", dbg_data, SZCy, e.r, e.szcy); end
  endtask

  task automatic test_multiply();
    exp_t e;
    logic [15:0] p;
    RD = 8'hFF; xsrc = 4'd6; xdst = 4'd6; step();
    xdst = 4'd8; xsrc = 4'd8; mul_start = 1'b1;
    p = 16'(8'hFF) * 16'(8'hFF);
    e.r = p[7:0]; e.h = p[15:8]; e.szcy = {p[15], (p == 16'h0000), (p[15:8] != 8'h00)};
    sb.push_back(e);
    step();
    RD = 8'h33; xsrc = 4'd6; xdst = 4'd6; aluop = 4'd0; Rwe = 1'b1; FLGwe = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (mul_busy !== 1'b1 || mul_done !== 1'b0)
        begin errors++; $display("[TB] FAIL mul_busy_c%0d: got busy=%b done=%b expected 1 0", c, mul_busy, mul_done); end
      step();
    end
    checks++;
    if (mul_done !== 1'b1 || mul_busy !== 1'b0)
      begin errors++; $display("[TB] FAIL mul_done_pulse: got busy=%b done=%b expected 0 1", mul_busy, mul_done); end
    e = sb.pop_front();
    dbg_addr = 4'd8; #1;
    checks++;
    if (dbg_data !== e.r) begin errors++; $display("[TB] FAIL mul_R: got %h expected %h", dbg_data, e.r); end
    dbg_addr = 4'd9; #1;
    checks++;
    if (dbg_data !== e.h) begin errors++; $display("[TB] FAIL mul_H: got %h expected %h", dbg_data, e.h); end
    checks++;
    if (SZCy !== e.szcy) begin errors++; $display("[TB] FAIL mul_SZCy: got %b expected %b", SZCy, e.szcy); end
    xdst = 4'd8;
    step();
    checks++;
    if (mul_busy !== 1'b0 || mul_done !== 1'b0)
      begin errors++; $display("[TB] FAIL mul_after_done: got busy=%b done=%b expected 0 0", mul_busy, mul_done); end
    dbg_addr = 4'd8; #1;
    checks++;
    if (dbg_data !== e.r) begin errors++; $display("[TB] FAIL mul_R_held: got %h expected %h", dbg_data, e.r); end
    dbg_addr = 4'd6; #1;
    checks++;
    if (dbg_data !== 8'h33) begin errors++; $display("[TB] FAIL mul_T_write: got %h expected 33", dbg_data); end
    Rwe = 1'b0; FLGwe = 1'b0; mul_start = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mc [3];
    logic [7:0] mp [3];
    exp_t e;
    logic [15:0] p;
    int waited;
    mc[0] = 8'h0D; mp[0] = 8'h0B;
    mc[1] = 8'h00; mp[1] = 8'h37;
    mc[2] = 8'h80; mp[2] = 8'h02;
    for (int n = 0; n < 3; n++) begin
      RD = mp[n]; xsrc = 4'd6; xdst = 4'd6; step();
      RD = mc[n]; xdst = 4'd8; mul_start = 1'b1;
      p = 16'(mc[n]) * 16'(mp[n]);
      e.r = p[7:0]; e.h = p[15:8]; e.szcy = {p[15], (p == 16'h0000), (p[15:8] != 8'h00)};
      sb.push_back(e);
      step();
      mul_start = 1'b0; RD = 8'hA5;
      waited = 0;
      while (mul_done !== 1'b1 && waited < 20) begin
        step();
        waited++;
      end
      checks++;
      if (mul_done !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b%0d_timeout: got no mul_done expected a pulse within 20 cycles", n);
        void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        dbg_addr = 4'd8; #1;
        checks++;
        if (dbg_data !== e.r) begin errors++; $display("[TB] FAIL b2b%0d_R: got %h expected %h", n, dbg_data, e.r); end
        dbg_addr = 4'd9; #1;
        checks++;
        if (dbg_data !== e.h) begin errors++; $display("[TB] FAIL b2b%0d_H: got %h expected %h", n, dbg_data, e.h); end
        checks++;
        if (SZCy !== e.szcy) begin errors++; $display("[TB] FAIL b2b%0d_SZCy: got %b expected %b", n, SZCy, e.szcy); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_mul();
    logic saw_done;
    xsrc = 4'd8; xdst = 4'd8; mul_start = 1'b1; step();
    mul_start = 1'b0; step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (mul_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", mul_busy); end
    dbg_addr = 4'd8; #1;
    checks++;
    if (dbg_data !== 8'h00) begin errors++; $display("[TB] FAIL abort_R: got %h expected 00", dbg_data); end
    dbg_addr = 4'd9; #1;
    checks++;
    if (dbg_data !== 8'h00) begin errors++; $display("[TB] FAIL abort_H: got %h expected 00", dbg_data); end
    saw_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (mul_done === 1'b1 || mul_busy === 1'b1) saw_done = 1'b1;
      step();
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got activity=1 expected 0"); end
  endtask

  task automatic test_null_dst();
    xsrc = 4'd8; xdst = 4'd8; step();
    for (int a = 0; a < 11; a++) begin
      dbg_addr = 4'(a); #1;
      checks++;
      if (dbg_data !== 8'h00)
        begin errors++; $display("[TB] FAIL null_dbg%0d: got %h expected 00", a, dbg_data); end
    end
    dbg_addr = 4'd11; #1;
    checks++;
    if (dbg_data !== 8'hFF) begin errors++; $display("[TB] FAIL null_xbus: got %h expected ff", dbg_data); end
    dbg_addr = 4'd12; #1;
    checks++;
    if (dbg_data !== 8'h00) begin errors++; $display("[TB] FAIL dbg_unused: got %h expected 00", dbg_data); end
    xdst = 4'd7; step();
    xdst = 4'd8;
    checks++;
    if (I !== 8'hFF) begin errors++; $display("[TB] FAIL const_to_I: got %h expected ff", I); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sbc();
    test_shift();
    test_multiply();
    test_back_to_back();
    test_reset_mid_mul();
    test_null_dst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/datapath_core_param.md
Name: datapath_core_param

Overview:
Parametrised successor of the 8-bit datapath core: a single-Xbus datapath without memory, with configurable data width and general-register count. Adds an iterative shift-add multiplier that owns the R/H result pair and uses a start/busy/done handshake, plus synchronous reset of every register. It sits between the controller unit (selects, aluop, handshake) and the memory unit (RD/WD/MA).

Parameters:
WIDTH, 8, datapath width in bits (>=4).
NREG, 4, general registers; register 0 is PC.
SELW, $clog2(NREG+5), width of xsrc/xdst (derived; do not override).
DBGW, $clog2(NREG+8), width of dbg_addr (derived).

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high; clears every register.
RD  in  WIDTH  memory read data.
WD  out  WIDTH  WDR contents (memory write data).
MA  out  WIDTH  MAR contents (memory address).
xsrc  in  SELW  Xbus source select.
xdst  in  SELW  Xbus destination select.
aluop  in  4  ALU operation.
Rwe  in  1  load R with ALU result.
FLGwe  in  1  load FLG with ALU flags.
mul_start  in  1  start multiply: multiplicand = Xbus, multiplier = T.
mul_busy  out  1  multiplier running.
mul_done  out  1  one-cycle pulse: product written.
I  out  WIDTH  instruction register.
SZCy  out  3  FLG[3:1] = {S,Z,Cy}.
dbg_addr  in  DBGW  debug select.
dbg_data  out  WIDTH  debug read data.

Behaviour:
- Reset: PC, all general regs, MAR, WDR, T, I, R, H, FLG = 0; mul_busy = 0, mul_done = 0; multiplier FSM -> IDLE. Reset mid-multiply aborts it with no mul_done.
- Xbus (combinational) by xsrc: 0..NREG-1 general regs; NREG R; NREG+1 H; NREG+2 RD; NREG+3 FLG; NREG+4 all-ones; other codes 0.
- xdst (written at clock edge from Xbus): 0..NREG-1 general regs; NREG MAR; NREG+1 WDR; NREG+2 T; NREG+3 I; other codes write nothing. Exactly one destination per cycle.
- ALU (combinational): a = Xbus, b = T, cin = FLG[1]. 0 pass a; 1 a+b; 2 a-b; 3 a&b; 4 a|b; 5 a^b; 6 a+b+cin; 7 a-b-cin; 8 a<<1; 9 a>>1 (logical); others pass a. Cy = carry out (add) / borrow (sub) / shifted-out bit (shift) / 0 (logic). S = result[WIDTH-1]; Z = (result == 0).
- FLG = {0..., S, Z, Cy, 0}; bits other than [3:1] are always 0.
- Rwe: R <= ALU result. FLGwe: FLG <= ALU flags. Both are ignored while mul_busy = 1 or mul_done = 1.
- Multiplier FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: mul_start = 1 latches Xbus and T; go to RUN; mul_busy = 1 from the next cycle.
  - RUN: runs exactly WIDTH cycles; each cycle does one shift-add step on a 2*WIDTH accumulator.
  - DONE: one cycle. mul_busy = 0, mul_done = 1. R = product[WIDTH-1:0], H = product[2W-1:WIDTH]. FLG: S = product[2W-1], Z = (product == 0), Cy = (H != 0).
  - Timing: mul_start sampled at edge k gives mul_done high in cycle k+WIDTH+1, with R/H/FLG valid in that same cycle.
  - mul_start while busy or during DONE is ignored.
- Xbus transfers to other destinations, and T/MAR/WDR/I writes, stay legal during RUN. They do not disturb the latched operands.
- dbg_addr: 0..NREG-1 general regs; NREG MAR; NREG+1 WDR; NREG+2 T; NREG+3 I; NREG+4 R; NREG+5 H; NREG+6 FLG; NREG+7 Xbus; others 0.

Test Plan:
(WIDTH=8, NREG=4: xsrc 6 = RD, 8 = FF; xdst 6 = T, 8 = none.)
1. Reset: assert reset 1 cycle -> MA = WD = I = 0, SZCy = 000, mul_busy = mul_done = 0, dbg 0..11 all read 0x00.
2. ADD: RD=0x7F, xsrc=6, xdst=6 (T=0x7F); then RD=0x01, xsrc=6, aluop=1, Rwe=FLGwe=1 -> R = 0x80, SZCy = 100.
3. SUB borrow then SBC: T=0x01, Xbus=0x00, aluop=2 -> R = 0xFF, SZCy = 101; then Xbus=0x05, T=0x01, aluop=7 -> R = 0x03.
4. Multiply: T=0xFF, xsrc=8, mul_start -> mul_busy 8 cycles. mul_done pulses at k+9 with R = 0x01, H = 0xFE, SZCy = 101. Extra mul_start and Rwe=1 while busy -> no effect.
5. Reset mid-multiply: assert reset 3 cycles after start -> next cycle mul_busy = 0, R = H = 0, and mul_done never pulses.
6. Null dst / const source: xsrc=8, xdst=8 -> no register changes; dbg_addr=11 reads 0xFF (Xbus). Then xdst=7 -> I = 0xFF.
